// File: rtl/if_id_stage.sv
// -----------------------------------------------------------------------------
// if_id_stage
//   Instruction-fetch stage and IF/ID pipeline register for a 5-stage RV32
//   pipeline. It holds the fetch PC, captures the fetched instruction into
//   the IF/ID register, and pre-decodes the immediate format so that the
//   immediate generator in ID sees a mode that always matches id_inst.
//
//   Control priority at each rising edge, highest first:
//     rst > br_taken > flush > stall > normal advance
//
// Parameters
//   RESET_PC   PC value loaded on reset.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous, active-high reset
//   stall      in   1   hold PC and IF/ID register
//   flush      in   1   insert a bubble into ID (PC still advances)
//   br_taken   in   1   redirect from EX (taken branch / jump)
//   br_target  in  32   redirect address (low two bits ignored)
//   inst_in    in  32   instruction memory read data for the current pc
//   pc         out 32   fetch address to instruction memory
//   id_pc      out 32   PC of the instruction in ID (0 for a bubble)
//   id_inst    out 32   instruction in ID (ADDI x0,x0,0 for a bubble)
//   id_mode    out  3   immediate-format code for id_inst
//   id_valid   out  1   id_inst is a real instruction
//   fetch_cnt  out 32   count of valid instructions that entered ID
// -----------------------------------------------------------------------------
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic [31:0] inst_in,
  output logic [31:0] pc,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic [2:0]  id_mode,
  output logic        id_valid,
  output logic [31:0] fetch_cnt
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;  // ADDI x0,x0,0

  // Immediate-format codes consumed by the immediate generator.
  localparam logic [2:0] MODE_NONE  = 3'd0;
  localparam logic [2:0] MODE_I     = 3'd1;
  localparam logic [2:0] MODE_SHAMT = 3'd2;
  localparam logic [2:0] MODE_U     = 3'd3;
  localparam logic [2:0] MODE_J     = 3'd4;
  localparam logic [2:0] MODE_B     = 3'd5;
  localparam logic [2:0] MODE_S     = 3'd6;

  logic [31:0] r_pc;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_inst;
  logic [2:0]  r_id_mode;
  logic        r_id_valid;
  logic [31:0] r_fetch_cnt;

  logic [31:0] w_pc_plus4;
  logic [2:0]  w_mode_in;
  logic [31:0] w_redirect_pc;

  // Redirect targets are always word aligned; the low bits are dropped.
  logic [1:0]  w_unused_tgt_lsb;
  assign w_unused_tgt_lsb = br_target[1:0];

  assign w_pc_plus4    = r_pc + 32'd4;  // wraps naturally modulo 2^32
  assign w_redirect_pc = {br_target[31:2], 2'b00};

  // Decode the immediate format of the instruction about to enter ID so the
  // mode is registered in lockstep with the instruction itself.
  always_comb begin
    w_mode_in = MODE_NONE;
    unique case (inst_in[6:0])
      7'b0010011: begin
        // Shift-immediates carry a shamt field, not a sign-extended imm.
        if (inst_in[14:12] == 3'b001 || inst_in[14:12] == 3'b101)
          w_mode_in = MODE_SHAMT;
        else
          w_mode_in = MODE_I;
      end
      7'b0000011: w_mode_in = MODE_I;   // loads
      7'b1100111: w_mode_in = MODE_I;   // JALR
      7'b0110111: w_mode_in = MODE_U;   // LUI
      7'b0010111: w_mode_in = MODE_U;   // AUIPC
      7'b1101111: w_mode_in = MODE_J;   // JAL
      7'b1100011: w_mode_in = MODE_B;   // branches
      7'b0100011: w_mode_in = MODE_S;   // stores
      default:    w_mode_in = MODE_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_id_pc     <= 32'd0;
      r_id_inst   <= NOP_INST;
      r_id_mode   <= MODE_I;
      r_id_valid  <= 1'b0;
      r_fetch_cnt <= 32'd0;
    end else if (br_taken) begin
      // Redirect wins over stall and flush: the wrong-path instruction is
      // squashed and fetch restarts at the target.
      r_pc        <= w_redirect_pc;
      r_id_pc     <= 32'd0;
      r_id_inst   <= NOP_INST;
      r_id_mode   <= MODE_I;
      r_id_valid  <= 1'b0;
    end else if (flush) begin
      // Fetch keeps moving; only the instruction entering ID is killed.
      r_pc        <= w_pc_plus4;
      r_id_pc     <= 32'd0;
      r_id_inst   <= NOP_INST;
      r_id_mode   <= MODE_I;
      r_id_valid  <= 1'b0;
    end else if (!stall) begin
      r_pc        <= w_pc_plus4;
      r_id_pc     <= r_pc;
      r_id_inst   <= inst_in;
      r_id_mode   <= w_mode_in;
      r_id_valid  <= 1'b1;
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign pc        = r_pc;
  assign id_pc     = r_id_pc;
  assign id_inst   = r_id_inst;
  assign id_mode   = r_id_mode;
  assign id_valid  = r_id_valid;
  assign fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] inst_in;

  logic [31:0] pc, id_pc, id_inst, fetch_cnt;
  logic [2:0]  id_mode;
  logic        id_valid;

  logic [31:0] w_pc, w_id_pc, w_id_inst, w_fetch_cnt;
  logic [2:0]  w_id_mode;
  logic        w_id_valid;

  int errors = 0;
  int checks = 0;

  if_id_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .br_taken(br_taken), .br_target(br_target), .inst_in(inst_in),
    .pc(pc), .id_pc(id_pc), .id_inst(id_inst), .id_mode(id_mode),
    .id_valid(id_valid), .fetch_cnt(fetch_cnt)
  );

  // Second instance for the PC wrap-around case.
  if_id_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .br_taken(br_taken), .br_target(br_target), .inst_in(inst_in),
    .pc(w_pc), .id_pc(w_id_pc), .id_inst(w_id_inst), .id_mode(w_id_mode),
    .id_valid(w_id_valid), .fetch_cnt(w_fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall, flush, br;
    logic [31:0] tgt, inst;
    logic [31:0] e_pc, e_id_pc, e_inst;
    logic [2:0]  e_mode;
    logic        e_valid;
    logic [31:0] e_cnt;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic f,
                       input logic b, input logic [31:0] t, input logic [31:0] i);
    rst = r; stall = s; flush = f; br_taken = b; br_target = t; inst_in = i;
  endtask

  // Reference model: the immediate format is a property of the opcode class.
  function automatic logic [2:0] ref_mode(input logic [31:0] ins);
    logic [6:0] op;
    logic [2:0] f3;
    op = ins[6:0];
    f3 = ins[14:12];
    case (op)
      7'h13:         return (f3 == 3'd1 || f3 == 3'd5) ? 3'd2 : 3'd1;
      7'h03, 7'h67:  return 3'd1;
      7'h37, 7'h17:  return 3'd3;
      7'h6F:         return 3'd4;
      7'h63:         return 3'd5;
      7'h23:         return 3'd6;
      default:       return 3'd0;
    endcase
  endfunction

  // Model state: what the stage should hold, expressed as plain values.
  logic [31:0] m_pc, m_id_pc, m_inst, m_cnt;
  logic        m_valid;

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops[10];
    logic [31:0] v;
    ops = '{7'h13, 7'h03, 7'h67, 7'h37, 7'h17, 7'h6F, 7'h63, 7'h23, 7'h33, 7'h7F};
    v = $urandom;
    v[6:0] = ops[$urandom_range(0, 9)];
    return v;
  endfunction

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    //          rst stall flush br  tgt            inst           e_pc           e_id_pc        e_inst         mode valid cnt
    vecs[0]  = '{1, 0, 0, 0, 32'h0,          32'h0050_0093, 32'h0,          32'h0,          32'h0000_0013, 3'd1, 0, 32'd0};
    vecs[1]  = '{0, 0, 0, 0, 32'h0,          32'h0050_0093, 32'h4,          32'h0,          32'h0050_0093, 3'd1, 1, 32'd1};
    vecs[2]  = '{0, 0, 0, 0, 32'h0,          32'h0050_0093, 32'h8,          32'h4,          32'h0050_0093, 3'd1, 1, 32'd2};
    vecs[3]  = '{0, 0, 0, 0, 32'h0,          32'h0050_0093, 32'hC,          32'h8,          32'h0050_0093, 3'd1, 1, 32'd3};
    vecs[4]  = '{1, 1, 0, 0, 32'h0,          32'h0050_0093, 32'h0,          32'h0,          32'h0000_0013, 3'd1, 0, 32'd0};
    vecs[5]  = '{0, 0, 0, 0, 32'h0,          32'h0050_0093, 32'h4,          32'h0,          32'h0050_0093, 3'd1, 1, 32'd1};
    vecs[6]  = '{0, 0, 0, 0, 32'h0,          32'h0050_0093, 32'h8,          32'h4,          32'h0050_0093, 3'd1, 1, 32'd2};
    vecs[7]  = '{0, 1, 0, 0, 32'h0,          32'h0020_81B3, 32'h8,          32'h4,          32'h0050_0093, 3'd1, 1, 32'd2};
    vecs[8]  = '{0, 1, 0, 0, 32'h0,          32'h0020_81B3, 32'h8,          32'h4,          32'h0050_0093, 3'd1, 1, 32'd2};
    vecs[9]  = '{0, 0, 0, 0, 32'h0,          32'h0050_0093, 32'hC,          32'h8,          32'h0050_0093, 3'd1, 1, 32'd3};
    vecs[10] = '{0, 1, 0, 1, 32'h0000_0103, 32'h0020_81B3, 32'h100,        32'h0,          32'h0000_0013, 3'd1, 0, 32'd3};
    vecs[11] = '{0, 0, 0, 0, 32'h0,          32'h0010_1013, 32'h104,        32'h100,        32'h0010_1013, 3'd2, 1, 32'd4};
    vecs[12] = '{0, 0, 0, 0, 32'h0,          32'h1234_5037, 32'h108,        32'h104,        32'h1234_5037, 3'd3, 1, 32'd5};
    vecs[13] = '{0, 0, 0, 0, 32'h0,          32'h0080_006F, 32'h10C,        32'h108,        32'h0080_006F, 3'd4, 1, 32'd6};
    vecs[14] = '{0, 0, 0, 0, 32'h0,          32'h0000_0463, 32'h110,        32'h10C,        32'h0000_0463, 3'd5, 1, 32'd7};
    vecs[15] = '{0, 0, 0, 0, 32'h0,          32'h0011_2023, 32'h114,        32'h110,        32'h0011_2023, 3'd6, 1, 32'd8};
    vecs[16] = '{0, 0, 0, 0, 32'h0,          32'h0020_81B3, 32'h118,        32'h114,        32'h0020_81B3, 3'd0, 1, 32'd9};
    vecs[17] = '{0, 1, 1, 0, 32'h0,          32'h0010_1013, 32'h11C,        32'h0,          32'h0000_0013, 3'd1, 0, 32'd9};
    vecs[18] = '{1, 1, 1, 1, 32'h0000_0200, 32'h0010_1013, 32'h0,          32'h0,          32'h0000_0013, 3'd1, 0, 32'd0};

    // Table-driven directed vectors.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].br, vecs[i].tgt, vecs[i].inst);
      @(posedge clk); #1;
      check($sformatf("v%0d pc", i),        pc,              vecs[i].e_pc);
      check($sformatf("v%0d id_pc", i),     id_pc,           vecs[i].e_id_pc);
      check($sformatf("v%0d id_inst", i),   id_inst,         vecs[i].e_inst);
      check($sformatf("v%0d id_mode", i),   {29'd0, id_mode}, {29'd0, vecs[i].e_mode});
      check($sformatf("v%0d id_valid", i),  {31'd0, id_valid}, {31'd0, vecs[i].e_valid});
      check($sformatf("v%0d fetch_cnt", i), fetch_cnt,       vecs[i].e_cnt);
      $display("vec %0d: rst=%0b stall=%0b flush=%0b br=%0b pc=%08h id_pc=%08h id_inst=%08h mode=%0d valid=%0b cnt=%0d",
               i, vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].br, pc, id_pc, id_inst, id_mode, id_valid, fetch_cnt);
    end

    // PC wrap: reset to 0xFFFFFFFC, then one normal edge.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0050_0093);
    @(posedge clk); #1;
    check("wrap reset pc", w_pc, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0050_0093);
    @(posedge clk); #1;
    check("wrap pc", w_pc, 32'h0000_0000);
    check("wrap id_pc", w_id_pc, 32'hFFFF_FFFC);
    check("wrap id_valid", {31'd0, w_id_valid}, 32'd1);
    $display("wrap: pc=%08h id_pc=%08h valid=%0b", w_pc, w_id_pc, w_id_valid);

    // Randomized stimulus against the behavioural model.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    m_pc = 32'd0; m_id_pc = 32'd0; m_inst = 32'h13; m_valid = 1'b0; m_cnt = 32'd0;
    for (int n = 0; n < 400; n++) begin
      logic r, s, f, b;
      logic [31:0] t, ins;
      r   = ($urandom_range(0, 31) == 0);
      b   = ($urandom_range(0, 7) == 0);
      f   = ($urandom_range(0, 7) == 0);
      s   = ($urandom_range(0, 3) == 0);
      t   = $urandom;
      ins = rand_inst();
      drive(r, s, f, b, t, ins);
      if (r) begin
        m_pc = 32'd0; m_id_pc = 32'd0; m_inst = 32'h13; m_valid = 1'b0; m_cnt = 32'd0;
      end else if (b) begin
        m_pc = t - (t % 4); m_id_pc = 32'd0; m_inst = 32'h13; m_valid = 1'b0;
      end else if (f) begin
        m_pc = m_pc + 4; m_id_pc = 32'd0; m_inst = 32'h13; m_valid = 1'b0;
      end else if (!s) begin
        m_id_pc = m_pc; m_pc = m_pc + 4; m_inst = ins; m_valid = 1'b1; m_cnt = m_cnt + 1;
      end
      @(posedge clk); #1;
      check($sformatf("r%0d pc", n),        pc,        m_pc);
      check($sformatf("r%0d id_pc", n),     id_pc,     m_id_pc);
      check($sformatf("r%0d id_inst", n),   id_inst,   m_inst);
      check($sformatf("r%0d id_mode", n),   {29'd0, id_mode}, {29'd0, ref_mode(m_inst)});
      check($sformatf("r%0d id_valid", n),  {31'd0, id_valid}, {31'd0, m_valid});
      check($sformatf("r%0d fetch_cnt", n), fetch_cnt, m_cnt);
      $display("rnd %0d: rst=%0b br=%0b flush=%0b stall=%0b inst=%08h pc=%08h id_pc=%08h mode=%0d cnt=%0d",
               n, r, b, f, s, ins, pc, id_pc, id_mode, fetch_cnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
